chunk_writer: RTL

- Producer end of the processing-chunk interface. Accepts a stream of audio samples over a valid/ready handshake and writes them into a ping-pong (two-bank) input buffer memory.
- When a bank holds IO_BUFF_SIZE samples, it issues chunk_pulse with the bank index to simple_processor.
- Holds the bank until the processor releases it with chunk_done, then reuses it. Applies backpressure upstream when both banks are occupied.

---
 rtl/chunk_pkg.sv | 14 +
 rtl/chunk_bank_tracker.sv | 71 +++++++
 rtl/chunk_writer.sv | 67 ++++++
 3 files changed

// File: rtl/chunk_pkg.sv
// rtl/chunk_pkg.sv - shared bank-state encoding and buffer sizing for the chunk interface
package chunk_pkg;

  localparam int DEF_SAMPLE_SIZE  = 24;
  localparam int DEF_IO_BUFF_SIZE = 64;

  typedef enum logic [1:0] {
    BANK_FREE       = 2'd0,
    BANK_FILLING    = 2'd1,
    BANK_FULL       = 2'd2,
    BANK_PROCESSING = 2'd3
  } bank_state_e;

endpackage

// File: rtl/chunk_bank_tracker.sv
// rtl/chunk_bank_tracker.sv - ping-pong bank ownership: fill, announce oldest full bank, release
module chunk_bank_tracker
  import chunk_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic accept,
  input  logic accept_last,
  input  logic wr_bank,
  input  logic chunk_done,
  output logic wr_bank_open,
  output logic chunk_pulse,
  output logic chunk_bank
);

  bank_state_e state_q    [2];
  bank_state_e state_next [2];
  logic        older_q;
  logic        older_next;
  logic        full0;
  logic        full1;
  logic        busy;
  logic        busy_bank;
  logic        cand;
  logic        announce;

  assign wr_bank_open = (state_q[wr_bank] == BANK_FREE) || (state_q[wr_bank] == BANK_FILLING);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q[0]  <= BANK_FREE;
      state_q[1]  <= BANK_FREE;
      older_q     <= 1'b0;
      chunk_pulse <= 1'b0;
      chunk_bank  <= 1'b0;
    end else begin
      state_q[0]  <= state_next[0];
      state_q[1]  <= state_next[1];
      older_q     <= older_next;
      chunk_pulse <= announce;
      if (announce) chunk_bank <= cand;
    end
  end

  // FULL is only seen one cycle after the final accept, so the announce
  // decided here lands after the last write pulse has reached memory.
  always_comb begin
    state_next[0] = state_q[0];
    state_next[1] = state_q[1];
    older_next    = older_q;
    full0         = (state_q[0] == BANK_FULL);
    full1         = (state_q[1] == BANK_FULL);
    busy          = (state_q[0] == BANK_PROCESSING) || (state_q[1] == BANK_PROCESSING);
    busy_bank     = (state_q[1] == BANK_PROCESSING);
    cand          = (full0 && full1) ? older_q : full1;
    announce      = (full0 || full1) && (!busy || chunk_done);

    if (chunk_done && busy) state_next[busy_bank] = BANK_FREE;
    if (announce) state_next[cand] = BANK_PROCESSING;

    if (accept) begin
      if (accept_last) begin
        state_next[wr_bank] = BANK_FULL;
        older_next = (state_q[~wr_bank] == BANK_FULL) ? ~wr_bank : wr_bank;
      end else begin
        state_next[wr_bank] = BANK_FILLING;
      end
    end
  end

endmodule

// File: rtl/chunk_writer.sv
// rtl/chunk_writer.sv - sample stream to ping-pong input buffer writer with chunk announce
module chunk_writer
  import chunk_pkg::*;
#(
  parameter int SAMPLE_SIZE      = DEF_SAMPLE_SIZE,
  parameter int IO_BUFF_SIZE     = DEF_IO_BUFF_SIZE,
  parameter int IO_BUFF_PTR_BITS = $clog2(IO_BUFF_SIZE)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_sample_valid,
  input  logic [SAMPLE_SIZE-1:0]      in_sample,
  output logic                        in_sample_ready,
  output logic                        input_buff_write_pulse,
  output logic                        input_buff_bank,
  output logic [IO_BUFF_PTR_BITS-1:0] input_buff_ptr,
  output logic [SAMPLE_SIZE-1:0]      input_buff_sample,
  output logic                        chunk_pulse,
  output logic                        chunk_bank,
  input  logic                        chunk_done,
  output logic                        overrun
);

  logic                        wr_bank;
  logic [IO_BUFF_PTR_BITS-1:0] wr_ptr;
  logic                        accept;
  logic                        accept_last;

  assign accept      = in_sample_valid && in_sample_ready;
  assign accept_last = (wr_ptr == IO_BUFF_PTR_BITS'(IO_BUFF_SIZE - 1));

  chunk_bank_tracker u_tracker (
    .clk          (clk),
    .rst_n        (rst_n),
    .accept       (accept),
    .accept_last  (accept_last),
    .wr_bank      (wr_bank),
    .chunk_done   (chunk_done),
    .wr_bank_open (in_sample_ready),
    .chunk_pulse  (chunk_pulse),
    .chunk_bank   (chunk_bank)
  );

  // Pointer wraps naturally because the bank size is a power of two.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_bank                <= 1'b0;
      wr_ptr                 <= '0;
      input_buff_write_pulse <= 1'b0;
      input_buff_bank        <= 1'b0;
      input_buff_ptr         <= '0;
      input_buff_sample      <= '0;
      overrun                <= 1'b0;
    end else begin
      input_buff_write_pulse <= accept;
      if (accept) begin
        wr_ptr            <= wr_ptr + IO_BUFF_PTR_BITS'(1);
        input_buff_bank   <= wr_bank;
        input_buff_ptr    <= wr_ptr;
        input_buff_sample <= in_sample;
        if (accept_last) wr_bank <= ~wr_bank;
      end
      if (in_sample_valid && !in_sample_ready) overrun <= 1'b1;
    end
  end

endmodule
